vga_scan_reader: RTL and testbench

Display-side reader for the filtered-image buffer. After the filter controller raises `VGA_EN`, this block generates 640x480 VGA raster timing. It drives row-major read addresses `VGA_ADDR` into the 256x256 filtered image. It returns the read data `VGA_DATA` as grayscale pixels, aligned with `HSYNC`, `VSYNC` and `DE`. The image is placed in a fixed window on a background of `BORDER`.

---
 rtl/vga_scan_reader.sv | 142 ++++++++++++++
 tb/tb_vga_scan_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_reader.sv
// VGA raster generator and read-address driver for the filtered image buffer.
// Control flags ride a delay line matched to the buffer read latency so sync, DE and pixel stay aligned.
module vga_scan_reader #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 16,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int IMG_X0  = 192,
    parameter int IMG_Y0  = 112,
    parameter int RD_LAT  = 1,
    parameter logic [D_WIDTH-1:0] BORDER = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VGA_EN,
    input  logic [D_WIDTH-1:0] VGA_DATA,
    output logic [A_WIDTH-1:0] VGA_ADDR,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DE,
    output logic [D_WIDTH-1:0] PIX_OUT,
    output logic               FRAME_START
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int IW    = A_WIDTH / 2;
    localparam int IMG_N = 2 ** IW;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] WX0    = HW'(IMG_X0);
    localparam logic [HW-1:0] WX1    = HW'(IMG_X0 + IMG_N);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] WY0    = VW'(IMG_Y0);
    localparam logic [VW-1:0] WY1    = VW'(IMG_Y0 + IMG_N);

    typedef enum logic {WAIT, SCAN} state_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic win;
        logic fs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, win: 1'b0, fs: 1'b0};

    state_t             state_q, state_d;
    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic [IW-1:0]      hx, vy;
    logic               in_win;
    ctrl_t              ctrl_d;
    logic [A_WIDTH-1:0] addr_d;
    ctrl_t [RD_LAT:0]   ctl_pipe;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (VGA_EN)  state_d = SCAN;
            SCAN:    if (!VGA_EN) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // Counters only advance while scanning with the enable still high; any other case parks them at 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state_q == SCAN && VGA_EN) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    always_comb begin
        hx     = IW'(h_cnt - WX0);
        vy     = IW'(v_cnt - WY0);
        in_win = (state_q == SCAN) && (h_cnt >= WX0) && (h_cnt < WX1) &&
                 (v_cnt >= WY0) && (v_cnt < WY1);
        ctrl_d = CTRL_IDLE;
        if (state_q == SCAN) begin
            ctrl_d.de  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            ctrl_d.hs  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
            ctrl_d.vs  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
            ctrl_d.win = in_win;
            ctrl_d.fs  = (h_cnt == '0) && (v_cnt == '0);
        end
        addr_d = in_win ? {vy, hx} : '0;
    end

    // Stage 0 launches the address; the RD_LAT stages behind it wait out the buffer read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            VGA_ADDR    <= '0;
            ctl_pipe    <= {(RD_LAT + 1){CTRL_IDLE}};
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            DE          <= 1'b0;
            PIX_OUT     <= '0;
            FRAME_START <= 1'b0;
        end else begin
            VGA_ADDR    <= addr_d;
            ctl_pipe[0] <= ctrl_d;
            for (int i = 1; i <= RD_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
            HSYNC       <= ctl_pipe[RD_LAT].hs;
            VSYNC       <= ctl_pipe[RD_LAT].vs;
            DE          <= ctl_pipe[RD_LAT].de;
            FRAME_START <= ctl_pipe[RD_LAT].fs;
            if (ctl_pipe[RD_LAT].win)     PIX_OUT <= VGA_DATA;
            else if (ctl_pipe[RD_LAT].de) PIX_OUT <= BORDER;
            else                          PIX_OUT <= '0;
        end
    end
endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader on a scaled raster (80x55 total, 64x48 active, 16x16 image at (20,10)).
// Two instances cover read latencies 1 and 3; a raster model feeds a pixel scoreboard drained on DE.
module tb_vga_scan_reader;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 80
    localparam int VT = VV + VF + VS + VB;   // 55
    localparam int FRAME = HT * VT;          // 4400
    localparam int X0 = 20, Y0 = 10, N = 16;
    localparam logic [7:0] BRD = 8'hA5;
    localparam int L1 = 3, L3 = 5;

    logic       CLK = 1'b0;
    logic       RST;
    logic       VGA_EN;
    logic [7:0] addr1, data1, pix1, addr3, data3, pix3;
    logic       hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    vga_scan_reader #(
        .D_WIDTH(8), .A_WIDTH(8), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .IMG_X0(X0), .IMG_Y0(Y0),
        .RD_LAT(1), .BORDER(BRD)
    ) u1 (
        .CLK(CLK), .RST(RST), .VGA_EN(VGA_EN), .VGA_DATA(data1), .VGA_ADDR(addr1),
        .HSYNC(hs1), .VSYNC(vs1), .DE(de1), .PIX_OUT(pix1), .FRAME_START(fs1)
    );

    vga_scan_reader #(
        .D_WIDTH(8), .A_WIDTH(8), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .IMG_X0(X0), .IMG_Y0(Y0),
        .RD_LAT(3), .BORDER(BRD)
    ) u3 (
        .CLK(CLK), .RST(RST), .VGA_EN(VGA_EN), .VGA_DATA(data3), .VGA_ADDR(addr3),
        .HSYNC(hs3), .VSYNC(vs3), .DE(de3), .PIX_OUT(pix3), .FRAME_START(fs3)
    );

    // Buffer models: q = low nibble of address XOR high nibble.
    logic [7:0] r3 [0:2];
    always @(posedge CLK) begin
        data1 <= {4'h0, addr1[3:0] ^ addr1[7:4]};
        r3[0] <= {4'h0, addr3[3:0] ^ addr3[7:4]};
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end
    assign data3 = r3[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Raster model of the expected counter position during each cycle.
    int m_scan = 0, mh = 0, mv = 0;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_scan <= 0; mh <= 0; mv <= 0;
        end else if (m_scan == 0) begin
            m_scan <= VGA_EN ? 1 : 0; mh <= 0; mv <= 0;
        end else if (!VGA_EN) begin
            m_scan <= 0; mh <= 0; mv <= 0;
        end else if (mh == HT - 1) begin
            mh <= 0;
            mv <= (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh <= mh + 1;
        end
    end

    int q1[$];
    int q3[$];
    always @(negedge CLK) begin
        int e;
        if (!RST && m_scan != 0 && mh < HV && mv < VV) begin
            if (mh >= X0 && mh < X0 + N && mv >= Y0 && mv < Y0 + N)
                e = ((mh - X0) ^ (mv - Y0)) & 15;
            else
                e = int'(BRD);
            q1.push_back(e);
            q3.push_back(e);
        end
    end

    always @(negedge CLK) begin
        int e;
        if (!RST) begin
            if (de1) begin
                if (q1.size() == 0) chk("pix1_unexpected_de", 1, 0);
                else begin e = q1.pop_front(); chk("pix1", int'(pix1), e); end
            end else chk("blank1", int'(pix1), 0);
            if (de3) begin
                if (q3.size() == 0) chk("pix3_unexpected_de", 1, 0);
                else begin e = q3.pop_front(); chk("pix3", int'(pix3), e); end
            end else chk("blank3", int'(pix3), 0);
        end
    end

    // Address checks: the model position of this cycle shows up on VGA_ADDR one cycle later.
    int tx [7] = '{20, 35, 30, 19, 36, 20, 27};
    int ty [7] = '{10, 25, 13, 10, 25, 26, 17};
    int ta [7] = '{8'h00, 8'hFF, 8'h3A, 8'h00, 8'h00, 8'h00, 8'h77};
    int a_pend = -1;
    always @(negedge CLK) begin
        if (a_pend >= 0) begin
            chk("addr1", int'(addr1), a_pend);
            chk("addr3", int'(addr3), a_pend);
        end
        a_pend = -1;
        if (!RST && m_scan != 0)
            for (int i = 0; i < 7; i++)
                if (mh == tx[i] && mv == ty[i]) a_pend = ta[i];
    end

    task automatic chk_idle(input string name);
        chk({name, "_1"}, int'({hs1, vs1, de1, fs1, pix1, addr1}), int'({4'b1100, 16'h0}));
        chk({name, "_3"}, int'({hs3, vs3, de3, fs3, pix3, addr3}), int'({4'b1100, 16'h0}));
    endtask

    task automatic restart_fs(input string name, input int t0);
        int f1 = -1, f3 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (fs1 && f1 < 0) f1 = cyc;
            if (fs3 && f3 < 0) f3 = cyc;
        end
        chk({name, "_fs1_at"}, f1 - t0, 1 + L1);
        chk({name, "_fs3_at"}, f3 - t0, 1 + L3);
    endtask

    initial begin
        int t0, td;
        int f1a = -1, f1b = -1, f3a = -1, f3b = -1, n_fs1 = 0;
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1;
        RST = 1'b1;
        VGA_EN = 1'b0;
        repeat (2) @(negedge CLK);
        chk_idle("reset");
        RST = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            chk_idle("wait");
        end

        VGA_EN = 1'b1;
        t0 = cyc;
        for (int k = 0; k < FRAME + 200; k++) begin
            @(negedge CLK);
            if (fs1) begin
                n_fs1++;
                if (f1a < 0) f1a = cyc; else if (f1b < 0) f1b = cyc;
            end
            if (fs3) begin
                if (f3a < 0) f3a = cyc; else if (f3b < 0) f3b = cyc;
            end
            if (f1a >= 0) begin
                if (cyc - f1a < HT) begin
                    de_cnt += int'(de1);
                    hs_cnt += int'(!hs1);
                    if (!hs1 && hs_first < 0) hs_first = cyc - f1a;
                end
                if (cyc - f1a < FRAME) begin
                    vs_cnt += int'(!vs1);
                    if (!vs1 && vs_first < 0) vs_first = cyc - f1a;
                end
            end
        end
        chk("fs1_first", f1a - t0, 1 + L1);
        chk("fs3_first", f3a - t0, 1 + L3);
        chk("fs1_period", f1b - f1a, FRAME);
        chk("fs3_period", f3b - f3a, FRAME);
        chk("fs1_count", n_fs1, 2);
        chk("de_per_line", de_cnt, HV);
        chk("hs_offset", hs_first, HV + HF);
        chk("hs_width", hs_cnt, HS);
        chk("vs_offset", vs_first, (VV + VF) * HT);
        chk("vs_width", vs_cnt, VS * HT);

        // Drop mid-frame, hold low, then reassert.
        for (int k = 0; k < 2 * FRAME && !(mv == 30 && mh == 5); k++) @(negedge CLK);
        chk("reach_line30", mv * HT + mh, 30 * HT + 5);
        VGA_EN = 1'b0;
        td = cyc;
        while (cyc < td + 1 + L3) @(negedge CLK);
        chk("drop_de1", int'(de1), 0);
        chk("drop_de3", int'(de3), 0);
        chk("drop_sync1", int'({hs1, vs1}), 3);
        chk("drop_sync3", int'({hs3, vs3}), 3);
        repeat (20) @(negedge CLK);
        chk_idle("dropped");
        VGA_EN = 1'b1;
        restart_fs("reassert", cyc);

        // One-cycle glitch on the enable restarts from (0,0).
        for (int k = 0; k < 2 * FRAME && !(mv == 2 && mh == 40); k++) @(negedge CLK);
        VGA_EN = 1'b0;
        @(negedge CLK);
        VGA_EN = 1'b1;
        restart_fs("glitch", cyc);

        repeat (300) @(negedge CLK);
        VGA_EN = 1'b0;
        repeat (20) @(negedge CLK);
        chk_idle("final");
        chk("q1_left", q1.size(), 0);
        chk("q3_left", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
